tdm_demux_1to8: RTL and testbench

Serial-to-parallel time-division demultiplexer: the receiving end of an 8:1 multiplexer link whose select is driven by a slot counter. Each accepted input beat is routed to the lane given by an internal slot counter. When slot 7 arrives, the completed 8-lane word is presented with a one-cycle valid pulse. A sync marker aligns the counter to slot 0, and sync misalignment is flagged.

---
 rtl/tdm_demux_1to8.sv | 117 +++++++++++
 tb/tb_tdm_demux_1to8.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1to8.sv
// 1:8 time-division demultiplexer: routes each accepted beat to the lane
// selected by a slot counter and publishes the full 8-lane word on slot 7.

module tdm_demux_lane #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module tdm_demux_1to8 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic           sync,
  input  logic [W-1:0]   din,
  output logic [8*W-1:0] out,
  output logic           out_valid,
  output logic [2:0]     slot,
  output logic           locked,
  output logic           frame_err
);
  localparam int NUM_LANES = 7;

  typedef enum logic [0:0] {HUNT, RUN} state_t;

  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       sh_we;
  logic [2:0] sh_idx;
  logic       out_ld;
  logic       ferr_nxt;
  logic [NUM_LANES-1:0][W-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_we     = 1'b0;
    sh_idx    = cnt;
    out_ld    = 1'b0;
    ferr_nxt  = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (sync) begin
            sh_we     = 1'b1;
            sh_idx    = 3'd0;
            cnt_nxt   = 3'd1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // A sync beat always restarts the frame; mid-frame it drops the partial word.
            sh_we    = 1'b1;
            sh_idx   = 3'd0;
            cnt_nxt  = 3'd1;
            ferr_nxt = (cnt != 3'd0);
          end else if (cnt == 3'd7) begin
            out_ld  = 1'b1;
            cnt_nxt = 3'd0;
          end else begin
            sh_we   = 1'b1;
            cnt_nxt = cnt + 3'd1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tdm_demux_lane #(.W(W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (sh_we && (sh_idx == 3'(i))),
      .d    (din),
      .q    (shadow[i])
    );
  end

  // Slot 7 bypasses the shadow so the word lands on the edge that accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= out_ld;
      frame_err <= ferr_nxt;
      if (out_ld) out <= {din, shadow};
    end
  end

  assign slot   = cnt;
  assign locked = (state == RUN);
endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Self-checking bench for tdm_demux_1to8 (W=4): directed frames plus random
// traffic against a queue-based frame model.

module tb_tdm_demux_1to8;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           sync = 1'b0;
  logic [W-1:0]   din = '0;
  logic [8*W-1:0] out;
  logic           out_valid;
  logic [2:0]     slot;
  logic           locked;
  logic           frame_err;

  int n_vec = 0;
  int n_err = 0;

  // reference model: beats of the frame being collected, in arrival order
  bit           mlocked;
  logic [W-1:0] mq[$];
  logic [8*W-1:0] mout;
  bit           exp_ov, exp_fe;
  int           ov_cnt, fe_cnt;

  tdm_demux_1to8 #(.W(W)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .sync     (sync),
    .din      (din),
    .out      (out),
    .out_valid(out_valid),
    .slot     (slot),
    .locked   (locked),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mlocked = 0;
    mq.delete();
    mout = '0;
    exp_ov = 0;
    exp_fe = 0;
  endtask

  task automatic model_beat(input bit v, input bit s, input logic [W-1:0] d);
    exp_ov = 0;
    exp_fe = 0;
    if (!v) return;
    if (!mlocked) begin
      if (s) begin
        mlocked = 1;
        mq = '{d};
      end
    end else if (s) begin
      if (mq.size() != 0) exp_fe = 1;
      mq = '{d};
    end else begin
      mq.push_back(d);
      if (mq.size() == 8) begin
        for (int k = 0; k < 8; k++) mout[k*W +: W] = mq[k];
        exp_ov = 1;
        mq.delete();
      end
    end
  endtask

  task automatic check_all();
    chk("out", 64'(out), 64'(mout));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("frame_err", 64'(frame_err), 64'(exp_fe));
    chk("slot", 64'(slot), 64'(mq.size()));
    chk("locked", 64'(locked), 64'(mlocked));
  endtask

  // inputs change 1 time unit after an edge; outputs sampled 1 unit after the next
  task automatic step(input bit v, input bit s, input logic [W-1:0] d);
    in_valid = v;
    sync     = s;
    din      = d;
    @(posedge clk);
    model_beat(v, s, d);
    if (exp_ov) ov_cnt++;
    if (exp_fe) fe_cnt++;
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [8*W-1:0] w, input bit s0, input int gap_after, input int gaps);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, s0 && (k == 0), w[k*W +: W]);
      if (k == gap_after)
        for (int g = 0; g < gaps; g++) step(1'b0, 1'($urandom), W'($urandom));
    end
  endtask

  // spread an 8-bit bus onto W-bit lanes, one bit per lane
  function automatic logic [8*W-1:0] bits(input logic [7:0] b);
    logic [8*W-1:0] r = '0;
    for (int k = 0; k < 8; k++) r[k*W] = b[k];
    return r;
  endfunction

  task automatic async_reset();
    in_valid = 1'($urandom);
    sync     = 1'($urandom);
    din      = W'($urandom);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    ov_cnt = 0;
    fe_cnt = 0;
    // held reset with random inputs
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom);
      sync     = 1'($urandom);
      din      = W'($urandom);
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;

    // basic frame 0x55, sync on first beat
    send_word(bits(8'h55), 1'b1, -1, 0);
    chk("basic_word", 64'(out), 64'(bits(8'h55)));
    chk("basic_pulses", 64'(ov_cnt), 64'd1);

    // hunt: fresh reset, 3 unsynced beats ignored, then 0xA3 with a 2-cycle gap
    async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'($urandom));
    chk("hunt_locked", 64'(locked), 64'd0);
    ov_cnt = 0;
    send_word(bits(8'hA3), 1'b1, 4, 2);
    chk("gap_word", 64'(out), 64'(bits(8'hA3)));
    chk("gap_pulses", 64'(ov_cnt), 64'd1);

    // back-to-back frames, sync only on the first
    ov_cnt = 0;
    send_word(bits(8'h0F), 1'b1, -1, 0);
    send_word(bits(8'hF0), 1'b0, -1, 0);
    send_word(bits(8'h81), 1'b0, -1, 0);
    chk("b2b_word", 64'(out), 64'(bits(8'h81)));
    chk("b2b_pulses", 64'(ov_cnt), 64'd3);

    // misaligned sync
    send_word(bits(8'h55), 1'b0, -1, 0);
    fe_cnt = 0;
    ov_cnt = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'($urandom));
    send_word(bits(8'h3C), 1'b1, -1, 0);
    chk("mis_ferr", 64'(fe_cnt), 64'd1);
    chk("mis_pulses", 64'(ov_cnt), 64'd1);
    chk("mis_word", 64'(out), 64'(bits(8'h3C)));

    // reset mid-frame, then a full 4-bit-lane frame
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'($urandom));
    async_reset();
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    send_word(32'h87654321, 1'b1, -1, 0);
    chk("w4_word", 64'(out), 64'h87654321);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
